// File: rtl/idver_reader.sv
// Reads the chip's static IDVER word: synchronizes it, waits for a run of
// identical samples, captures it and compares the ID and version halves.
module idver_reader #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] EXP_IDVER  = 32'h3100_0014
) (
    input  logic        CLK60MHZ,
    input  logic        RESET,
    input  logic        CLK60MHZLOCK,
    input  logic [31:0] IDVER_IN,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        VALID,
    output logic [31:0] IDVAL,
    output logic        IDMATCH,
    output logic        VERMATCH,
    output logic        TIMEOUT_ERR
);

    localparam logic [3:0]  STABLE_LIM  = 4'(STABLE_CNT);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SAMPLE,
        FIN
    } state_t;

    state_t      state;
    logic [31:0] meta;
    logic [31:0] sync;
    logic [31:0] prev;
    logic [3:0]  scnt;
    logic [15:0] tcnt;
    logic        flush;

    logic        restart;
    logic [3:0]  scnt_next;
    logic [15:0] tcnt_next;
    logic        stable_hit;
    logic        timeout_hit;
    logic        id_eq;
    logic        ver_eq;

    // Free-running two-flop synchronizer; runs regardless of the FSM state.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge CLK60MHZ or posedge RESET) begin
        if (RESET) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= IDVER_IN;
            sync <= meta;
        end
    end

    // Post-update counter values for the current SAMPLE edge.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        restart   = (sync != prev) || (scnt == 4'd0);
        scnt_next = scnt;
        if (restart) begin
            scnt_next = 4'd1;
        end else if (scnt < STABLE_LIM) begin
            scnt_next = scnt + 4'd1;
        end
        tcnt_next   = (tcnt < TIMEOUT_LIM) ? tcnt + 16'd1 : tcnt;
        stable_hit  = (scnt_next == STABLE_LIM);
        timeout_hit = (tcnt_next == TIMEOUT_LIM);
        id_eq       = (sync[31:16] == EXP_IDVER[31:16]);
        ver_eq      = (sync[15:0]  == EXP_IDVER[15:0]);
    end

    always_ff @(posedge CLK60MHZ or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            VALID       <= 1'b0;
            IDVAL       <= '0;
            IDMATCH     <= 1'b0;
            VERMATCH    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            prev        <= '0;
            scnt        <= '0;
            tcnt        <= '0;
            flush       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && CLK60MHZLOCK) begin
                        state       <= SYNC;
                        BUSY        <= 1'b1;
                        VALID       <= 1'b0;
                        IDMATCH     <= 1'b0;
                        VERMATCH    <= 1'b0;
                        TIMEOUT_ERR <= 1'b0;
                        scnt        <= '0;
                        tcnt        <= '0;
                        flush       <= 1'b0;
                    end
                end

                SYNC: begin
                    if (!CLK60MHZLOCK) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (flush) begin
                        state <= SAMPLE;
                    end else begin
                        flush <= 1'b1;
                    end
                end

                SAMPLE: begin
                    if (!CLK60MHZLOCK) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        tcnt <= tcnt_next;
                        scnt <= scnt_next;
                        if (restart) begin
                            prev <= sync;
                        end
                        // Stability is tested first so it wins a same-edge tie.
                        if (stable_hit) begin
                            state       <= FIN;
                            IDVAL       <= sync;
                            VALID       <= 1'b1;
                            IDMATCH     <= id_eq;
                            VERMATCH    <= ver_eq;
                            TIMEOUT_ERR <= 1'b0;
                        end else if (timeout_hit) begin
                            state       <= FIN;
                            IDVAL       <= sync;
                            VALID       <= 1'b0;
                            IDMATCH     <= 1'b0;
                            VERMATCH    <= 1'b0;
                            TIMEOUT_ERR <= 1'b1;
                        end
                    end
                end

                FIN: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idver_reader.sv
// Randomized bench for idver_reader; expectations come from a window-based
// model over the driven input pattern (first run of STABLE_CNT equal samples).
module tb_idver_reader;

    localparam int          S   = 4;
    localparam int          T   = 255;
    localparam logic [31:0] EXP = 32'h3100_0014;
    localparam int          LEN = T + 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic        start;
    logic [31:0] idver_in;
    logic        busy, done, valid, idmatch, vermatch, timeout_err;
    logic [31:0] idval;

    int checks   = 0;
    int failures = 0;

    logic [31:0] pat [0:LEN+4];
    logic [31:0] m_idval;
    logic        m_valid, m_idm, m_verm, m_to;

    idver_reader #(.STABLE_CNT(S), .TIMEOUT(T), .EXP_IDVER(EXP)) dut (
        .CLK60MHZ     (clk),
        .RESET        (rst),
        .CLK60MHZLOCK (lock),
        .IDVER_IN     (idver_in),
        .START        (start),
        .BUSY         (busy),
        .DONE         (done),
        .VALID        (valid),
        .IDVAL        (idval),
        .IDMATCH      (idmatch),
        .VERMATCH     (vermatch),
        .TIMEOUT_ERR  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, " idval"},    idval,               m_idval);
        check({tag, " valid"},    32'(valid),          32'(m_valid));
        check({tag, " idmatch"},  32'(idmatch),        32'(m_idm));
        check({tag, " vermatch"}, 32'(vermatch),       32'(m_verm));
        check({tag, " timeout"},  32'(timeout_err),    32'(m_to));
    endtask

    function automatic logic [31:0] pick(input logic [31:0] a, input logic [31:0] b);
        case ($urandom_range(0, 3))
            0:       return a;
            1:       return b;
            2:       return EXP;
            default: return $urandom;
        endcase
    endfunction

    // kind 0: constant a; 1: toggle a/b every 3 cycles; 2: toggle until stop;
    // 3: random changes until stop.
    task automatic fill_pat(input int kind, input logic [31:0] a, input logic [31:0] b,
                            input int stop);
        for (int k = 0; k <= LEN + 4; k++) begin
            int kk;
            kk = (kind == 2 && k > stop) ? stop : k;
            case (kind)
                0: pat[k] = a;
                1, 2: pat[k] = ((kk / 3) % 2 == 1) ? b : a;
                default: begin
                    if (k == 0) pat[k] = a;
                    else if (k <= stop && $urandom_range(0, 2) == 0) pat[k] = pick(a, b);
                    else pat[k] = pat[k-1];
                end
            endcase
        end
    endtask

    // Sample j (1-based) of a read is pat[j]; capture is the first j whose
    // last S samples agree, otherwise a timeout on sample T.
    task automatic run_read(input string tag, input int hold);
        int  jcap;
        bit  to;
        int  done_k;
        int  ndone;
        jcap = T;
        to   = 1'b1;
        for (int j = S; j <= T; j++) begin
            bit same;
            same = 1'b1;
            for (int i = j - S + 1; i < j; i++) begin
                if (pat[i] !== pat[j]) same = 1'b0;
            end
            if (same) begin
                jcap = j;
                to   = 1'b0;
                break;
            end
        end
        m_idval = pat[jcap];
        m_valid = !to;
        m_idm   = !to && (pat[jcap][31:16] == EXP[31:16]);
        m_verm  = !to && (pat[jcap][15:0]  == EXP[15:0]);
        m_to    = to;

        @(negedge clk);
        start    = 1'b1;
        idver_in = pat[0];
        done_k   = -1;
        ndone    = 0;
        for (int k = 0; k < LEN; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, " busy_after_e0"}, 32'(busy), 32'd1);
            if (done) begin
                ndone++;
                if (done_k < 0) begin
                    done_k = k;
                    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
                end
            end
            start    = (k + 1 < hold);
            idver_in = pat[k+1];
            if (done_k >= 0 && k == done_k + 2) break;
        end
        start = 1'b0;
        check({tag, " done_edge"}, 32'(done_k), 32'(3 + jcap));
        check({tag, " done_pulses"}, 32'(ndone), 32'd1);
        check_results(tag);
    endtask

    initial begin
        rst      = 1'b1;
        lock     = 1'b1;
        start    = 1'b0;
        idver_in = '0;
        m_idval  = '0;
        m_valid  = 1'b0;
        m_idm    = 1'b0;
        m_verm   = 1'b0;
        m_to     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check_results("reset");
        rst = 1'b0;
        @(negedge clk);

        fill_pat(0, EXP, EXP, 0);
        run_read("nominal", 1);
        fill_pat(0, 32'h3100_0015, 0, 0);
        run_read("ver_mismatch", 1);
        fill_pat(0, 32'h3200_0014, 0, 0);
        run_read("id_mismatch", 1);
        fill_pat(1, EXP, 32'h3100_0015, 0);
        run_read("toggle_timeout", 1);
        fill_pat(2, EXP, 32'h3100_0015, 10);
        run_read("toggle_stop", 1);

        // START held across a long read: only one read may result.
        fill_pat(2, 32'h3100_0015, EXP, 20);
        run_read("start_held", 20);
        repeat (4) @(negedge clk);
        check("start_held no_retrigger", 32'(busy), 32'd0);

        // START while unlocked is ignored.
        lock  = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("nolock busy", 32'(busy), 32'd0);
        end
        start = 1'b0;
        lock  = 1'b1;
        check_results("nolock");

        // Abort: lock drops so that E5 samples it low.
        fill_pat(0, EXP, EXP, 0);
        run_read("pre_abort", 1);
        begin
            int ndone;
            ndone = 0;
            @(negedge clk);
            start    = 1'b1;
            idver_in = EXP;
            for (int k = 0; k <= 12; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) ndone++;
                if (k == 4) check("abort busy_e4", 32'(busy), 32'd1);
                if (k == 4) lock = 1'b0;
                if (k == 5) check("abort busy_e5", 32'(busy), 32'd0);
            end
            lock    = 1'b1;
            m_valid = 1'b0;
            m_idm   = 1'b0;
            m_verm  = 1'b0;
            m_to    = 1'b0;
            check("abort done_pulses", 32'(ndone), 32'd0);
            check_results("abort");
        end

        // Asynchronous reset mid-read.
        @(negedge clk);
        start    = 1'b1;
        idver_in = 32'h3200_0015;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        m_idval = '0;
        m_valid = 1'b0;
        m_idm   = 1'b0;
        m_verm  = 1'b0;
        m_to    = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check_results("midreset");
        @(negedge clk);
        rst = 1'b0;
        fill_pat(0, EXP, EXP, 0);
        run_read("after_reset", 1);

        // Randomized reads.
        for (int i = 0; i < 12; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 1) kind = 3;
            fill_pat(kind, pick(EXP, 32'h3200_0014), pick(32'h3100_0015, EXP),
                     $urandom_range(0, 40));
            run_read($sformatf("rand%0d", i), $urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
